// File: rtl/cpu_pkg.sv
// Constants shared across the CPU datapath.
// The ALU add path reads the add/sub op encoding from here.
package cpu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The master modport belongs to the producer/consumer; slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/pipelined_adder_add_slice.sv
// Combinational W-bit slice adder, one per pipeline stage.
// c_msb is the carry into the top bit, needed for signed overflow.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] sum_w;

  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  end

  assign s     = sum_w[W-1:0];
  assign co    = sum_w[W];
  // sum bit = a ^ b ^ carry_in, so the incoming carry falls out directly
  assign c_msb = a[W-1] ^ b[W-1] ^ sum_w[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into CHUNK-bit slices, one slice per stage,
// with the carry registered between stages and a single global advance.
module pipelined_adder
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_adder_if.slave   bus
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  // Index k of the *_in/*_d/*_q arrays is the slot that adds slice k;
  // *_q[k] is the register written by slot k.
  logic [STAGES-1:0][WIDTH-1:0] acc_in, acc_d, acc_q;
  logic [STAGES-1:0][WIDTH-1:0] b_in, b_d, b_q;
  logic [STAGES-1:0]            c_in, c_d, c_q;
  logic [STAGES-1:0][CHUNK-1:0] sum_w;
  logic [STAGES-1:0]            co_w, cm_w;
  logic                         cm_d, cm_q;
  logic [STAGES:1]              vld_d, vld_q;
  logic [STAGES:0]              vld_pipe;
  logic                         adv;

  assign vld_pipe = {vld_q, bus.in_valid};
  assign adv      = !vld_q[STAGES] || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    add_slice #(.W(CHUNK)) u_add (
      .a     (acc_in[k][CHUNK-1:0]),
      .b     (b_in[k][CHUNK-1:0]),
      .ci    (c_in[k]),
      .s     (sum_w[k]),
      .co    (co_w[k]),
      .c_msb (cm_w[k])
    );
  end

  // Slot 0 takes the raw operands; subtract is A + ~B + 1.
  always_comb begin
    acc_in    = '0;
    b_in      = '0;
    c_in      = '0;
    acc_in[0] = bus.a;
    b_in[0]   = bus.b ^ {WIDTH{bus.sub == OP_SUB}};
    c_in[0]   = (bus.sub == OP_ADD) ? bus.cin : 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      acc_in[k] = acc_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
    end
  end

  // acc rotates right by one slice per stage: the pending A slice leaves the
  // bottom and the finished sum slice enters the top, so after the last
  // stage acc holds the complete result in place.
  always_comb begin
    acc_d = '0;
    b_d   = '0;
    c_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      acc_d[k] = WIDTH'({sum_w[k], acc_in[k]} >> CHUNK);
      b_d[k]   = b_in[k] >> CHUNK;
      c_d[k]   = co_w[k];
    end
    vld_d = vld_pipe[STAGES-1:0];
    cm_d  = cm_w[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
      c_q   <= '0;
      cm_q  <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cm_q  <= cm_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES];
  assign bus.s         = acc_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = c_q[STAGES-1] ^ cm_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded bench for pipelined_adder at three geometries:
// 4/4 (single stage), 16/4 (default) and 32/8.
`timescale 1ns/1ps
module tb_pipelined_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // id 0: 4/4, id 1: 16/4, id 2: 32/8
  logic [2:0][31:0] t_a, t_b, r_s;
  logic [2:0]       t_cin, t_sub, t_iv, t_ordy;
  logic [2:0]       r_ov, r_ir, r_cout, r_ovf;

  pipelined_adder_if #(.WIDTH(4))  if4  ();
  pipelined_adder_if #(.WIDTH(16)) if16 ();
  pipelined_adder_if #(.WIDTH(32)) if32 ();

  assign if4.in_valid  = t_iv[0];   assign if4.out_ready  = t_ordy[0];
  assign if4.a         = t_a[0][3:0];
  assign if4.b         = t_b[0][3:0];
  assign if4.cin       = t_cin[0];  assign if4.sub        = t_sub[0];
  assign if16.in_valid = t_iv[1];   assign if16.out_ready = t_ordy[1];
  assign if16.a        = t_a[1][15:0];
  assign if16.b        = t_b[1][15:0];
  assign if16.cin      = t_cin[1];  assign if16.sub       = t_sub[1];
  assign if32.in_valid = t_iv[2];   assign if32.out_ready = t_ordy[2];
  assign if32.a        = t_a[2];
  assign if32.b        = t_b[2];
  assign if32.cin      = t_cin[2];  assign if32.sub       = t_sub[2];

  assign r_s    = {if32.s, 16'h0, if16.s, 28'h0, if4.s};
  assign r_ov   = {if32.out_valid, if16.out_valid, if4.out_valid};
  assign r_ir   = {if32.in_ready, if16.in_ready, if4.in_ready};
  assign r_cout = {if32.cout, if16.cout, if4.cout};
  assign r_ovf  = {if32.ovf, if16.ovf, if4.ovf};

  pipelined_adder #(.WIDTH(4),  .CHUNK(4)) u4  (.clk(clk), .rst(rst), .bus(if4));
  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(if16));
  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst(rst), .bus(if32));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t hv(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic sub, input logic [31:0] s, input logic cout,
                              input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.cout = cout; v.ovf = ovf;
    return v;
  endfunction

  // Reference: plain wide arithmetic; overflow from operand/result signs.
  function automatic vec_t mk(input int w, input logic [31:0] a_i, input logic [31:0] b_i,
                              input logic cin_i, input logic sub_i);
    logic [63:0] m, a, b, full;
    logic        sa, sb, ss, co;
    m = (64'd1 << w) - 64'd1;
    a = {32'h0, a_i} & m;
    b = {32'h0, b_i} & m;
    if (sub_i) begin
      full = a - b;
      co   = (a >= b);
    end else begin
      full = a + b + {63'h0, cin_i};
      co   = full[w];
    end
    full = full & m;
    sa = a[w-1]; sb = b[w-1]; ss = full[w-1];
    return hv(a[31:0], b[31:0], cin_i, sub_i, full[31:0], co,
              sub_i ? (sa != sb && ss != sa) : (sa == sb && ss != sa));
  endfunction

  task automatic drive(input int id, input vec_t v);
    t_a[id] = v.a; t_b[id] = v.b; t_cin[id] = v.cin; t_sub[id] = v.sub;
  endtask

  vec_t ops[$];

  // Streams ops[] into DUT id; every cycle with out_valid the head result is
  // checked, so a stalled result must hold its value until drained.
  task automatic run(input int id, input string tag, input int stall_from, input int stall_len,
                     input bit rnd_rdy, input bit bubbles, input int launch_pct);
    int sent, got, cyc, extra, n, budget;
    sent = 0; got = 0; cyc = 0; extra = 0;
    n = ops.size();
    budget = n * 12 + 50;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (rnd_rdy) t_ordy[id] = ($urandom_range(3) != 0);
      else         t_ordy[id] = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (sent < n && (bubbles ? (cyc % 2 == 0) : ($urandom_range(99) < launch_pct))) begin
        drive(id, ops[sent]);
        t_iv[id] = 1'b1;
      end else begin
        t_iv[id] = 1'b0;
      end
      #1;
      if (r_ov[id]) begin
        chk({tag, "_s"},    r_s[id],    ops[got].s);
        chk({tag, "_cout"}, r_cout[id], ops[got].cout);
        chk({tag, "_ovf"},  r_ovf[id],  ops[got].ovf);
        if (!t_ordy[id]) chk({tag, "_stall_in_ready"}, r_ir[id], 0);
        else got++;
      end else begin
        chk({tag, "_in_ready"}, r_ir[id], 1);
      end
      if (t_iv[id] && r_ir[id]) sent++;
      cyc++;
    end
    chk({tag, "_count"}, got, n);
    t_iv[id] = 1'b0;
    t_ordy[id] = 1'b1;
    repeat (12) begin
      @(negedge clk); #1;
      if (r_ov[id]) extra++;
    end
    chk({tag, "_extra"}, extra, 0);
  endtask

  // One op into an empty pipe; counts cycles from the accept edge to out_valid.
  task automatic lat(input int id, input string tag, input vec_t v, input int exp_lat);
    int l;
    @(negedge clk);
    drive(id, v);
    t_iv[id] = 1'b1;
    t_ordy[id] = 1'b1;
    #1 chk({tag, "_accept"}, r_ir[id], 1);
    @(negedge clk);
    t_iv[id] = 1'b0;
    l = 1;
    #1;
    while (!r_ov[id] && l < 20) begin
      @(negedge clk); #1;
      l++;
    end
    chk({tag, "_latency"}, l, exp_lat);
    chk({tag, "_s"},    r_s[id],    v.s);
    chk({tag, "_cout"}, r_cout[id], v.cout);
    chk({tag, "_ovf"},  r_ovf[id],  v.ovf);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl16[$];
    vec_t rv[3];
    int   extra;

    t_a = '0; t_b = '0; t_cin = '0; t_sub = '0; t_iv = '0; t_ordy = '0;
    rst = 1'b1;

    // Hand-computed 16-bit vectors {a, b, cin, sub, s, cout, ovf}
    tbl16.push_back(hv(32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0));
    tbl16.push_back(hv(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1));
    tbl16.push_back(hv(32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0));
    tbl16.push_back(hv(32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1));
    tbl16.push_back(hv(32'h1234, 32'h4321, 1'b1, 1'b0, 32'h5556, 1'b0, 1'b0));
    tbl16.push_back(hv(32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1));
    tbl16.push_back(hv(32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0));
    tbl16.push_back(hv(32'h0FFF, 32'h0000, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b0));
    tbl16.push_back(hv(32'h0007, 32'h0007, 1'b1, 1'b1, 32'h0000, 1'b1, 1'b0));
    tbl16.push_back(hv(32'h0000, 32'h0001, 1'b1, 1'b1, 32'hFFFF, 1'b0, 1'b0));
    tbl16.push_back(hv(32'h8000, 32'hFFFF, 1'b0, 1'b0, 32'h7FFF, 1'b1, 1'b1));
    tbl16.push_back(hv(32'h1234, 32'h8000, 1'b0, 1'b1, 32'h9234, 1'b0, 1'b1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) begin
      chk("reset_out_valid", r_ov[id],   0);
      chk("reset_s",         r_s[id],    0);
      chk("reset_cout",      r_cout[id], 0);
      chk("reset_ovf",       r_ovf[id],  0);
      chk("reset_in_ready",  r_ir[id],   1);
    end

    // Single-stage degenerate geometry: latency 1, then every A/B/cin.
    lat(0, "w4_lat", hv(32'hF, 32'h1, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0), 1);
    ops.delete();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          ops.push_back(mk(4, 32'(a), 32'(b), c[0], 1'b0));
    run(0, "w4_exh", 0, 0, 1'b0, 1'b0, 100);

    lat(1, "w16_lat_ffff", tbl16[0], 4);
    lat(1, "w16_lat_7fff", tbl16[1], 4);
    lat(1, "w16_lat_sub",  tbl16[2], 4);
    ops = tbl16;
    run(1, "w16_dir", 0, 0, 1'b0, 1'b0, 100);

    ops.delete();
    for (int i = 0; i < 10; i++)
      ops.push_back(mk(16, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))));
    run(1, "w16_stall", 5, 5, 1'b0, 1'b0, 100);

    ops.delete();
    for (int i = 0; i < 8; i++)
      ops.push_back(mk(16, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))));
    run(1, "w16_bubble", 0, 0, 1'b0, 1'b1, 100);

    // Three ops in flight, then a one-cycle reset: none may appear.
    rv[0] = hv(32'h1111, 32'h2222, 1'b0, 1'b0, 32'h3333, 1'b0, 1'b0);
    rv[1] = hv(32'h4444, 32'h1111, 1'b0, 1'b1, 32'h3333, 1'b1, 1'b0);
    rv[2] = hv(32'h0F00, 32'h00F0, 1'b1, 1'b0, 32'h0FF1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, rv[i]);
      t_iv[1] = 1'b1;
      t_ordy[1] = 1'b1;
    end
    @(negedge clk);
    t_iv[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", r_ov[1], 0);
    chk("rst_mid_in_ready",  r_ir[1], 1);
    extra = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (r_ov[1]) extra++;
    end
    chk("rst_mid_flushed", extra, 0);
    lat(1, "rst_next", hv(32'h0F0F, 32'h0101, 1'b1, 1'b0, 32'h1011, 1'b0, 1'b0), 4);

    lat(2, "w32_lat", hv(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0), 4);
    ops.delete();
    for (int i = 0; i < 10000; i++)
      ops.push_back(mk(32, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))));
    run(2, "w32_rnd", 0, 0, 1'b1, 1'b0, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
